bool_input_conditioner: RTL and testbench

Input-conditioning stage placed directly upstream of the boolean logger's data_in. It synchronises an asynchronous raw boolean into the logger clock domain and rejects pulses shorter than a programmable minimum width. It emits a clean level, single-cycle rise/fall strobes, and a saturating count of rejected glitches. The logger consumes data_out as its data_in and can use the strobes to close run-length entries.

---
 rtl/bool_input_conditioner.sv | 141 ++++++++++++++
 tb/tb_bool_input_conditioner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bool_input_conditioner.sv
// Input conditioner: synchronises raw_in, then accepts a new level only after it has held
// for FilterCycles synchronised cycles. Emits rise/fall strobes and a saturating glitch count.
module bool_input_conditioner #(
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned FilterCycles = 3,
  parameter int unsigned CountWidth   = 16
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_areset,
  input  logic                  raw_in,
  input  logic                  enable,
  input  logic                  glitch_clear,
  output logic                  data_out,
  output logic                  rise_pulse,
  output logic                  fall_pulse,
  output logic [CountWidth-1:0] glitch_count
);

  localparam int unsigned PendWidth = $clog2(FilterCycles) + 1;
  localparam logic [PendWidth-1:0] PendOne  = PendWidth'(1);
  localparam logic [PendWidth-1:0] PendLast = PendWidth'(FilterCycles - 1);

  typedef enum logic [1:0] {
    STABLE_LO,
    PEND_HI,
    STABLE_HI,
    PEND_LO
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SyncStages-1:0]   r_sync;
  logic [PendWidth-1:0]    r_pend_cnt;
  logic [PendWidth-1:0]    w_pend_cnt_nxt;
  logic                    w_s;
  logic                    w_accept_rise;
  logic                    w_accept_fall;
  logic                    w_reject;
  logic                    w_data_nxt;
  logic [CountWidth-1:0]   w_count_nxt;

  assign w_s = r_sync[SyncStages-1];

  // State register, synchroniser and registered outputs
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_sync       <= '0;
      r_state      <= STABLE_LO;
      r_pend_cnt   <= '0;
      data_out     <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      glitch_count <= '0;
    end else begin
      r_sync       <= {r_sync[SyncStages-2:0], raw_in};
      r_state      <= w_state_nxt;
      r_pend_cnt   <= w_pend_cnt_nxt;
      data_out     <= w_data_nxt;
      rise_pulse   <= w_accept_rise;
      fall_pulse   <= w_accept_fall;
      glitch_count <= w_count_nxt;
    end
  end

  // Next-state logic; disabling abandons a pending change without counting it as a glitch
  always_comb begin
    w_state_nxt    = r_state;
    w_pend_cnt_nxt = r_pend_cnt;
    w_accept_rise  = 1'b0;
    w_accept_fall  = 1'b0;
    w_reject       = 1'b0;
    unique case (r_state)
      STABLE_LO: begin
        if (enable && w_s) begin
          w_state_nxt    = PEND_HI;
          w_pend_cnt_nxt = PendOne;
        end
      end
      PEND_HI: begin
        if (!enable) begin
          w_state_nxt    = STABLE_LO;
          w_pend_cnt_nxt = '0;
        end else if (w_s) begin
          if (r_pend_cnt == PendLast) begin
            w_state_nxt    = STABLE_HI;
            w_pend_cnt_nxt = '0;
            w_accept_rise  = 1'b1;
          end else begin
            w_pend_cnt_nxt = r_pend_cnt + 1'b1;
          end
        end else begin
          w_state_nxt    = STABLE_LO;
          w_pend_cnt_nxt = '0;
          w_reject       = 1'b1;
        end
      end
      STABLE_HI: begin
        if (enable && !w_s) begin
          w_state_nxt    = PEND_LO;
          w_pend_cnt_nxt = PendOne;
        end
      end
      PEND_LO: begin
        if (!enable) begin
          w_state_nxt    = STABLE_HI;
          w_pend_cnt_nxt = '0;
        end else if (!w_s) begin
          if (r_pend_cnt == PendLast) begin
            w_state_nxt    = STABLE_LO;
            w_pend_cnt_nxt = '0;
            w_accept_fall  = 1'b1;
          end else begin
            w_pend_cnt_nxt = r_pend_cnt + 1'b1;
          end
        end else begin
          w_state_nxt    = STABLE_HI;
          w_pend_cnt_nxt = '0;
          w_reject       = 1'b1;
        end
      end
      default: begin
        w_state_nxt    = STABLE_LO;
        w_pend_cnt_nxt = '0;
      end
    endcase
  end

  // Output logic; clear takes priority over a same-cycle rejection
  always_comb begin
    w_data_nxt  = data_out;
    w_count_nxt = glitch_count;
    if (w_accept_rise) w_data_nxt = 1'b1;
    if (w_accept_fall) w_data_nxt = 1'b0;
    if (glitch_clear) begin
      w_count_nxt = '0;
    end else if (w_reject && (glitch_count != '1)) begin
      w_count_nxt = glitch_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_bool_input_conditioner.sv
// Scoreboard bench: stimulus pushes run-length-model predictions, a monitor pops and compares
// each cycle against a default instance and a CountWidth=3 instance.
module tb_bool_input_conditioner;

  localparam int SYNC = 2;
  localparam int FILT = 3;

  typedef struct packed {
    logic        d;
    logic        r;
    logic        f;
    logic [15:0] g;
    logic        d3;
    logic        r3;
    logic        f3;
    logic [2:0]  g3;
  } obs_t;

  logic clk = 1'b0;
  logic rst, raw, en, clr;
  logic d16, r16, f16;
  logic [15:0] g16;
  logic d3, r3, f3;
  logic [2:0] g3;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  obs_t expq[$];

  // reference model state: delay line, accepted level, run length of disagreeing samples
  logic [SYNC-1:0] m_hist = '0;
  logic m_lvl = 1'b0;
  int   m_run = 0;
  int   m_g16 = 0;
  int   m_g3  = 0;

  always #5 clk = ~clk;

  bool_input_conditioner #(
    .SyncStages(SYNC), .FilterCycles(FILT), .CountWidth(16)
  ) u_dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst), .raw_in(raw), .enable(en),
    .glitch_clear(clr), .data_out(d16), .rise_pulse(r16), .fall_pulse(f16),
    .glitch_count(g16)
  );

  bool_input_conditioner #(
    .SyncStages(SYNC), .FilterCycles(FILT), .CountWidth(3)
  ) u_dut3 (
    .s00_axi_aclk(clk), .s00_axi_areset(rst), .raw_in(raw), .enable(en),
    .glitch_clear(clr), .data_out(d3), .rise_pulse(r3), .fall_pulse(f3),
    .glitch_count(g3)
  );

  task automatic cyc(input logic i_raw, input logic i_en, input logic i_clr, input logic i_rst);
    logic s, rise, fall, rej;
    obs_t e;
    @(negedge clk);
    raw = i_raw; en = i_en; clr = i_clr; rst = i_rst;
    rise = 1'b0; fall = 1'b0; rej = 1'b0;
    if (i_rst) begin
      m_hist = '0; m_lvl = 1'b0; m_run = 0; m_g16 = 0; m_g3 = 0;
    end else begin
      s = m_hist[SYNC-1];
      m_hist = {m_hist[SYNC-2:0], i_raw};
      if (!i_en) begin
        m_run = 0;
      end else if (s != m_lvl) begin
        m_run++;
        if (m_run == FILT) begin
          m_lvl = s; m_run = 0;
          if (s) rise = 1'b1; else fall = 1'b1;
        end
      end else if (m_run > 0) begin
        rej = 1'b1; m_run = 0;
      end
      if (i_clr) begin
        m_g16 = 0; m_g3 = 0;
      end else if (rej) begin
        if (m_g16 < 65535) m_g16++;
        if (m_g3 < 7) m_g3++;
      end
    end
    e.d = m_lvl; e.r = rise; e.f = fall; e.g = 16'(m_g16);
    e.d3 = m_lvl; e.r3 = rise; e.f3 = fall; e.g3 = 3'(m_g3);
    expq.push_back(e);
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int p = 0; p < n; p++) begin
      repeat (hi) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (lo) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // monitor: every cycle the DUT presents a fresh registered output word
  initial begin
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        a = '{d: d16, r: r16, f: f16, g: g16, d3: d3, r3: r3, f3: f3, g3: g3};
        total++;
        if (a !== e || (r16 && f16)) begin
          bad++;
          $display("FAIL outputs cycle=%0d got d=%b r=%b f=%b g=%0d d3=%b r3=%b f3=%b g3=%0d want d=%b r=%b f=%b g=%0d g3=%0d",
                   cycle, a.d, a.r, a.f, a.g, a.d3, a.r3, a.f3, a.g3, e.d, e.r, e.f, e.g, e.g3);
        end
      end
    end
  end

  initial begin
    logic rv;
    int   rem;
    raw = 1'b1; en = 1'b1; clr = 1'b0; rst = 1'b1;

    // reset with raw high, then acceptance after release
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 1'b0);

    // 1-, 2-, 3-cycle pulses
    repeat (8) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    pulses(1, 1, 5);
    pulses(1, 2, 5);
    pulses(1, 3, 8);

    // short low dip while high
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 1'b0);

    // disabled toggling, then re-enable with opposite level
    for (int i = 0; i < 20; i++) cyc(((i / 4) % 2) != 0, 1'b0, 1'b0, 1'b0);
    repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // saturation of the 3-bit counter, then clear on the same edge as a rejection
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    pulses(9, 1, 5);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // reset while pending high with two samples counted
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (7) cyc(1'b1, 1'b1, 1'b0, 1'b0);

    // randomized run-length stimulus
    rv = 1'b1; rem = 0;
    for (int i = 0; i < 3000; i++) begin
      if (rem == 0) begin
        rv  = ~rv;
        rem = int'($urandom_range(1, 6));
      end
      rem--;
      cyc(rv, $urandom_range(0, 19) != 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 399) == 0);
    end

    repeat (3) @(negedge clk);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
